io_result_collector: RTL and testbench

- Host-side (io_clk domain) consumer of the accelerator's 11-bit output FIFO port (out_fifo_rdata / out_fifo_rempty_n / out_fifo_deq).
- Pops the word stream and reassembles 64-bit best-array entries, 6 words each, least-significant word first.
- Presents entries on a valid/ready interface and signals completion after a programmed number of entries.
- Sits directly downstream of the accelerator's output FIFO pins, on the board/FPGA side or in the chip-level test harness.

---
 rtl/io_result_collector_pkg.sv | 24 ++
 rtl/io_word_assembler.sv | 52 +++++
 rtl/io_result_collector.sv | 127 ++++++++++++
 tb/tb_io_result_collector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_result_collector_pkg
// Purpose  : Shared widths and FSM encoding for the result collector.
// Revision : 1.0
// ============================================================================
package io_result_collector_pkg;

    localparam int WORD_W = 11;
    localparam int RES_W  = 64;
    localparam int WPR    = (RES_W + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = 16;
    localparam int WIDX_W = $clog2(WPR);
    // Bits of the final word that carry payload; the rest must be zero pad
    localparam int LAST_W = RES_W - (WPR - 1) * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/io_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : io_word_assembler
// Purpose  : Packs FIFO words LSW-first into one entry and checks last-word pad.
// Revision : 1.0
// ============================================================================
module io_word_assembler
    import io_result_collector_pkg::*;
(
    input  logic              io_clk,
    input  logic              io_rst_n,
    input  logic              clr,
    input  logic              deq,
    input  logic [WORD_W-1:0] word,
    output logic [WIDX_W-1:0] widx,
    output logic              entry_stb,
    output logic [RES_W-1:0]  entry_data,
    output logic              pad_err
);

    localparam int BODY_W = (WPR - 1) * WORD_W;
    localparam logic [WIDX_W-1:0] C_LAST_IDX = WIDX_W'(WPR - 1);

    logic [BODY_W-1:0] r_body;
    logic [WIDX_W-1:0] r_widx;
    logic              w_last;

    assign w_last     = (r_widx == C_LAST_IDX);
    assign entry_stb  = deq && w_last;
    // The last word is used directly, so the entry is complete on its own deq
    assign entry_data = {word[LAST_W-1:0], r_body};
    assign pad_err    = entry_stb && (|word[WORD_W-1:LAST_W]);
    assign widx       = r_widx;

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_widx <= '0;
            r_body <= '0;
        end else if (clr) begin
            r_widx <= '0;
            r_body <= '0;
        end else if (deq) begin
            r_widx <= w_last ? '0 : r_widx + 1'b1;
            for (int k = 0; k < WPR - 1; k++) begin
                if (r_widx == WIDX_W'(k))
                    r_body[k*WORD_W +: WORD_W] <= word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : io_result_collector
// Purpose  : Drains the accelerator output FIFO into 64-bit valid/ready entries.
// Revision : 1.0
// ============================================================================
module io_result_collector
    import io_result_collector_pkg::*;
(
    input  logic              io_clk,
    input  logic              io_rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  expect_cnt,
    input  logic              out_fifo_rempty_n,
    input  logic [WORD_W-1:0] out_fifo_rdata,
    output logic              out_fifo_deq,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [CNT_W-1:0]  res_count,
    output logic              done,
    output logic              fmt_err
);

    localparam logic [WIDX_W-1:0] C_LAST_IDX = WIDX_W'(WPR - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_expect;
    logic [CNT_W-1:0]   r_res_count;
    logic [CNT_W-1:0]   r_asm_count;
    logic               r_done;
    logic               r_fmt_err;
    logic               r_res_valid;
    logic [RES_W-1:0]   r_res_data;

    logic               w_start_ok;
    logic               w_hs;
    logic               w_deq;
    logic               w_entry_stb;
    logic               w_pad_err;
    logic [WIDX_W-1:0]  w_widx;
    logic [RES_W-1:0]   w_entry;

    assign w_start_ok = start && (r_state != ST_COLLECT);
    assign w_hs       = r_res_valid && res_ready;
    // The last word may only be popped if the output register can take the entry
    assign w_deq      = (r_state == ST_COLLECT) && out_fifo_rempty_n &&
                        (r_asm_count < r_expect) &&
                        ((w_widx != C_LAST_IDX) || !r_res_valid || res_ready);

    io_word_assembler u_asm (
        .io_clk     (io_clk),
        .io_rst_n   (io_rst_n),
        .clr        (w_start_ok),
        .deq        (w_deq),
        .word       (out_fifo_rdata),
        .widx       (w_widx),
        .entry_stb  (w_entry_stb),
        .entry_data (w_entry),
        .pad_err    (w_pad_err)
    );

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_state     <= ST_IDLE;
            r_expect    <= '0;
            r_res_count <= '0;
            r_asm_count <= '0;
            r_done      <= 1'b0;
            r_fmt_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_expect    <= expect_cnt;
                        r_res_count <= '0;
                        r_asm_count <= '0;
                        r_fmt_err   <= 1'b0;
                        if (expect_cnt == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_COLLECT;
                            r_done  <= 1'b0;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_entry_stb) begin
                        r_asm_count <= r_asm_count + 1'b1;
                        if (w_pad_err)
                            r_fmt_err <= 1'b1;
                    end
                    if (w_hs && (r_res_count < r_expect)) begin
                        r_res_count <= r_res_count + 1'b1;
                        if ((r_res_count + 1'b1) == r_expect) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_entry_stb) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_entry;
        end else if (w_hs) begin
            r_res_valid <= 1'b0;
        end
    end

    assign out_fifo_deq = w_deq;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_count    = r_res_count;
    assign done         = r_done;
    assign fmt_err      = r_fmt_err;

endmodule
`default_nettype wire

// File: tb/tb_io_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_result_collector
// Purpose  : Scoreboard bench with a behavioural FWFT FIFO feeding the collector.
// Revision : 1.0
// ============================================================================
module tb_io_result_collector;
    import io_result_collector_pkg::*;

    logic              io_clk = 1'b0;
    logic              io_rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  expect_cnt = '0;
    logic              out_fifo_rempty_n = 1'b0;
    logic [WORD_W-1:0] out_fifo_rdata = '0;
    logic              out_fifo_deq;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [RES_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;
    logic              done;
    logic              fmt_err;

    always #5 io_clk = ~io_clk;

    io_result_collector dut (
        .io_clk            (io_clk),
        .io_rst_n          (io_rst_n),
        .start             (start),
        .expect_cnt        (expect_cnt),
        .out_fifo_rempty_n (out_fifo_rempty_n),
        .out_fifo_rdata    (out_fifo_rdata),
        .out_fifo_deq      (out_fifo_deq),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .res_count         (res_count),
        .done              (done),
        .fmt_err           (fmt_err)
    );

    logic [WORD_W-1:0] fifo_q [$];
    logic [RES_W-1:0]  exp_q [$];
    logic [WORD_W-1:0] wbuf [WPR];
    logic [WORD_W-1:0] wres [WPR];
    bit                fifo_en = 1'b1;
    logic              s_done = 1'b0;
    int n_tests = 0, n_fail = 0;
    int deq_cnt = 0, hs_cnt = 0, valid_cyc = 0, cyc = 0;
    int last_deq_cyc = -1, done_cyc = -1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] pack(input logic [WORD_W-1:0] w [WPR]);
        logic [RES_W-1:0] r = '0;
        for (int k = 0; k < WPR; k++)
            r = r | (RES_W'(w[k]) << (WORD_W * k));
        return r;
    endfunction

    task automatic fill_rand(input logic [WORD_W-1:0] last);
        for (int k = 0; k < WPR - 1; k++)
            wbuf[k] = WORD_W'($urandom_range(0, 2047));
        wbuf[WPR-1] = last;
    endtask

    task automatic push_entry(input bit expected);
        for (int k = 0; k < WPR; k++)
            fifo_q.push_back(wbuf[k]);
        if (expected)
            exp_q.push_back(pack(wbuf));
    endtask

    // One clock: present FIFO head, sample just before the edge, pop after it
    task automatic cycle();
        bit popped = 1'b0;
        out_fifo_rempty_n = fifo_en && (fifo_q.size() != 0);
        out_fifo_rdata    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        s_done = done;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (res_valid) valid_cyc++;
        if (out_fifo_deq) begin
            check("deq_while_empty", out_fifo_rempty_n, 1'b1);
            popped = out_fifo_rempty_n;
            deq_cnt++;
            last_deq_cyc = cyc;
        end
        if (res_valid && res_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("res_unexpected", 1'b1, 1'b0);
            else                   check("res_data", res_data, exp_q.pop_front());
        end
        @(negedge io_clk);
        if (popped) void'(fifo_q.pop_front());
        cyc++;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        expect_cnt = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
        deq_cnt = 0; hs_cnt = 0; valid_cyc = 0;
        done_cyc = -1; last_deq_cyc = -1;
    endtask

    task automatic run_until_done(input int bound, input bit toggle);
        int i = 0;
        do begin
            if (toggle) fifo_en = ~fifo_en;
            cycle();
            i++;
        end while (!s_done && i < bound);
        fifo_en = 1'b1;
        if (!s_done) check("done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge io_clk);
        #1;
        check("rst_deq", out_fifo_deq, 1'b0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_data", res_data, 64'h0);
        check("rst_count", res_count, 0);
        check("rst_done", done, 1'b0);
        check("rst_fmt_err", fmt_err, 1'b0);
        @(negedge io_clk);
        io_rst_n = 1'b1;
        cycle();

        // Single entry with fixed words
        wbuf = '{11'h7FF, 11'h000, 11'h555, 11'h2AA, 11'h123, 11'h1FF};
        push_entry(1'b1);
        res_ready = 1'b1;
        start_run(1);
        run_until_done(40, 1'b0);
        check("t1_deq_cnt", deq_cnt, 6);
        check("t1_hs_cnt", hs_cnt, 1);
        check("t1_valid_pulse", valid_cyc, 1);
        check("t1_res_count", res_count, 1);
        check("t1_done_latency", done_cyc - last_deq_cyc, 2);
        check("t1_fmt_err", fmt_err, 1'b0);

        // Backpressure: three entries, sink stalled until cycle 30
        for (int e = 0; e < 4; e++) begin
            fill_rand(WORD_W'($urandom_range(0, 511)));
            push_entry(e < 3);
        end
        res_ready = 1'b0;
        start_run(3);
        repeat (29) cycle();
        check("t2_stall_deq", deq_cnt, 11);
        check("t2_hold_valid", res_valid, 1'b1);
        check("t2_hold_data", res_data, exp_q[0]);
        check("t2_hold_hs", hs_cnt, 0);
        res_ready = 1'b1;
        run_until_done(100, 1'b0);
        repeat (3) cycle();
        check("t2_deq_total", deq_cnt, 18);
        check("t2_hs_cnt", hs_cnt, 3);
        check("t2_res_count", res_count, 3);
        check("t2_fifo_left", fifo_q.size(), 6);
        check("t2_exp_left", exp_q.size(), 0);
        fifo_q.delete();

        // FIFO head valid toggling every cycle
        fill_rand(WORD_W'($urandom_range(0, 511)));
        push_entry(1'b1);
        start_run(1);
        run_until_done(60, 1'b1);
        check("t3_deq_cnt", deq_cnt, 6);
        check("t3_hs_cnt", hs_cnt, 1);

        // Nonzero pad in the last word
        fill_rand(11'h600);
        push_entry(1'b1);
        start_run(1);
        run_until_done(40, 1'b0);
        check("t4_fmt_err", fmt_err, 1'b1);
        check("t4_hs_cnt", hs_cnt, 1);
        repeat (3) cycle();
        check("t4_fmt_sticky", fmt_err, 1'b1);

        // Zero-length run: no pops, done next cycle, fmt_err cleared
        fill_rand(WORD_W'($urandom_range(0, 511)));
        push_entry(1'b0);
        start_run(0);
        cycle();
        check("t5_done", s_done, 1'b1);
        check("t5_fmt_clr", fmt_err, 1'b0);
        repeat (2) cycle();
        check("t5_no_deq", deq_cnt, 0);
        check("t5_fifo_kept", fifo_q.size(), 6);

        // start while collecting is ignored
        exp_q.push_back(pack(wbuf));
        res_ready = 1'b0;
        start_run(1);
        cycle();
        expect_cnt = '0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("t5_ignored_start", done, 1'b0);
        res_ready = 1'b1;
        run_until_done(40, 1'b0);
        check("t5_res_count", res_count, 1);
        check("t5_hs_cnt", hs_cnt, 1);

        // Asynchronous reset after three words of an entry
        fill_rand(WORD_W'($urandom_range(0, 511)));
        push_entry(1'b0);
        for (int k = 0; k < 3; k++) wres[k] = wbuf[k + 3];
        fill_rand(WORD_W'($urandom_range(0, 511)));
        for (int k = 0; k < 3; k++) begin
            fifo_q.push_back(wbuf[k]);
            wres[k + 3] = wbuf[k];
        end
        start_run(1);
        for (int i = 0; i < 20 && deq_cnt < 3; i++) cycle();
        check("t6_pre_deq", deq_cnt, 3);
        io_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", res_valid, 1'b0);
        check("t6_rst_data", res_data, 64'h0);
        check("t6_rst_count", res_count, 0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_deq", out_fifo_deq, 1'b0);
        @(negedge io_clk);
        io_rst_n = 1'b1;
        check("t6_fifo_kept", fifo_q.size(), 6);
        exp_q.push_back(pack(wres));
        start_run(1);
        run_until_done(40, 1'b0);
        check("t6_deq_cnt", deq_cnt, 6);
        check("t6_hs_cnt", hs_cnt, 1);
        check("t6_exp_left", exp_q.size(), 0);
        check("t6_fifo_empty", fifo_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
